dmem_lsu: RTL and testbench

//  Load/store initiator between the pipeline MEM stage and the data memory block. Accepts one
//  RV32I load/store per handshake, checks alignment and address map, and drives the memory strobes.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_decode.sv | 54 +++++
 rtl/dmem_lsu.sv | 153 +++++++++++++++
 tb/tb_dmem_lsu.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: funct3 codes, sign_mask
// fields, FSM state encoding and the default address map.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] SM_BYTE = 3'b001;
  localparam logic [2:0] SM_HALF = 3'b011;
  localparam logic [2:0] SM_WORD = 3'b111;
  localparam logic [3:0] SM_SIGN = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  localparam logic [31:0] DEF_DMEM_BASE = 32'h0000_1000;
  localparam int unsigned DEF_DMEM_SIZE = 4096;
  localparam logic [31:0] DEF_LED_ADDR  = 32'h0000_2000;

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of an RV32I load/store: access size/sign mask, store lane
// shift, alignment fault and illegal funct3.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       i_write,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic [4:0] o_shamt,
  output logic       o_misaligned,
  output logic       o_illegal
);

  always_comb begin
    o_sign_mask  = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    o_shamt      = {i_addr_lo, 3'b000};
    if (i_write) begin
      case (i_funct3)
        F3_SB: o_sign_mask = {1'b0, SM_BYTE};
        F3_SH: begin
          o_sign_mask  = {1'b0, SM_HALF};
          o_misaligned = i_addr_lo[0];
        end
        F3_SW: begin
          o_sign_mask  = {1'b0, SM_WORD};
          o_misaligned = |i_addr_lo;
        end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_LB:  o_sign_mask = SM_SIGN | {1'b0, SM_BYTE};
        F3_LH: begin
          o_sign_mask  = SM_SIGN | {1'b0, SM_HALF};
          o_misaligned = i_addr_lo[0];
        end
        F3_LW: begin
          o_sign_mask  = {1'b0, SM_WORD};
          o_misaligned = |i_addr_lo;
        end
        F3_LBU: o_sign_mask = {1'b0, SM_BYTE};
        F3_LHU: begin
          o_sign_mask  = {1'b0, SM_HALF};
          o_misaligned = i_addr_lo[0];
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the pipeline MEM stage and the data memory.
// Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready is high only in IDLE, and resp_valid is an unstallable one-cycle pulse.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE,
  parameter int unsigned DMEM_SIZE = DEF_DMEM_SIZE,
  parameter logic [31:0] LED_ADDR  = DEF_LED_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  output logic [2:0]  dbg_state
);

  lsu_state_e  r_state, w_state_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_mask, w_mem_mask_nxt;
  logic        r_memread, w_memread_nxt;
  logic        r_memwrite, w_memwrite_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
  logic        r_resp_err, w_resp_err_nxt;

  logic [3:0]  w_sign_mask;
  logic [4:0]  w_shamt;
  logic        w_misaligned, w_illegal;
  logic [31:0] w_off;
  logic        w_in_ram, w_mapped, w_err;

  lsu_decode u_decode (
    .i_write      (req_write),
    .i_funct3     (req_funct3),
    .i_addr_lo    (req_addr[1:0]),
    .o_sign_mask  (w_sign_mask),
    .o_shamt      (w_shamt),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  // Offset compare avoids overflow of DMEM_BASE+DMEM_SIZE at the top of the map.
  assign w_off    = req_addr - DMEM_BASE;
  assign w_in_ram = (req_addr >= DMEM_BASE) && (w_off < DMEM_SIZE);
  assign w_mapped = w_in_ram || (req_write && (req_addr == LED_ADDR));
  assign w_err    = w_illegal || w_misaligned || !w_mapped;

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_mask_nxt   = r_mem_mask;
    w_memread_nxt    = 1'b0;
    w_memwrite_nxt   = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = '0;
    w_resp_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_mem_mask_nxt  = '0;
        if (req_valid) begin
          if (w_err) begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else if (req_write) begin
            w_state_nxt     = ST_WR_ISSUE;
            w_memwrite_nxt  = 1'b1;
            w_mem_addr_nxt  = req_addr;
            w_mem_mask_nxt  = w_sign_mask;
            w_mem_wdata_nxt = req_wdata << w_shamt;
          end else begin
            w_state_nxt    = ST_RD_ISSUE;
            w_memread_nxt  = 1'b1;
            w_mem_addr_nxt = req_addr;
            w_mem_mask_nxt = w_sign_mask;
          end
        end
      end
      ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        w_state_nxt      = ST_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = mem_read_data;
      end
      ST_WR_ISSUE: begin
        w_state_nxt      = ST_RESP;
        w_resp_valid_nxt = 1'b1;
      end
      ST_RESP: begin
        w_state_nxt     = ST_IDLE;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_mem_mask_nxt  = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_mask   <= '0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_mask   <= w_mem_mask_nxt;
      r_memread    <= w_memread_nxt;
      r_memwrite   <= w_memwrite_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  assign stall          = (r_state != ST_IDLE);
  assign dbg_state      = r_state;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_sign_mask  = r_mem_mask;
  assign mem_memread    = r_memread;
  assign mem_memwrite   = r_memwrite;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array memory responder, byte-level reference model,
// expected-queue scoreboard with cycle-exact latency checks.
module tb_dmem_lsu;
  import lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned SIZE = 4096;
  localparam logic [31:0] LED  = 32'h0000_2000;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [2:0]  dbg_state;

  dmem_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int unsigned cyc;
  } acc_t;

  resp_t exp_q[$];
  acc_t  acc_q[$];

  int checks = 0;
  int errors = 0;
  int exp_rd = 0, exp_wr = 0, act_rd = 0, act_wr = 0;

  logic [7:0]  ref_mem[SIZE];
  logic [7:0]  dev_mem[SIZE];
  logic [31:0] led_reg = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void ref_decode(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                     output logic err, output logic [3:0] mask, output int width);
    logic legal_f3, aligned, mapped, sgn;
    legal_f3 = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    width    = 1 << f3[1:0];
    aligned  = (a % width) == 0;
    mapped   = (a >= BASE && a < BASE + SIZE) || (w && a == LED);
    err      = !(legal_f3 && aligned && mapped);
    sgn      = !w && (f3 < 3'd4) && (width < 4);
    mask     = '0;
    if (!err)
      mask = {sgn, (width == 1) ? 3'b001 : (width == 2) ? 3'b011 : 3'b111};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int width, input logic sgn);
    logic [31:0] v = '0;
    int off = int'(a - BASE);
    for (int i = 0; i < width; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
    if (sgn && width == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && width == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] word);
    int off = int'(a - BASE);
    for (int i = 0; i < 4; i++) begin
      ref_mem[off + i] = word[8*i +: 8];
      dev_mem[off + i] = word[8*i +: 8];
    end
  endtask

  // ---------------- memory responder (the data memory block) ----------------
  always @(negedge clk) begin
    int width, lo, off;
    logic [31:0] v;
    case (mem_sign_mask[2:0])
      3'b001:  width = 1;
      3'b011:  width = 2;
      3'b111:  width = 4;
      default: width = 0;
    endcase
    lo  = int'(mem_addr[1:0]);
    off = int'(mem_addr - BASE);
    if (mem_memwrite) begin
      if (mem_addr == LED) led_reg = mem_write_data;
      else if (mem_addr >= BASE && mem_addr < BASE + SIZE)
        for (int i = 0; i < width; i++)
          if (lo + i < 4 && off + i < int'(SIZE)) dev_mem[off + i] = mem_write_data[8*(lo+i) +: 8];
    end
    if (mem_memread) begin
      v = '0;
      if (mem_addr >= BASE && mem_addr < BASE + SIZE)
        for (int i = 0; i < width; i++)
          if (off + i < int'(SIZE)) v = v | (32'(dev_mem[off + i]) << (8 * i));
      if (mem_sign_mask[3] && width == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (mem_sign_mask[3] && width == 2 && v[15]) v = v | 32'hFFFF_0000;
      mem_read_data = v;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    acc_t  a;
    resp_t r;
    if (!reset) begin
      check("ready_vs_stall", 32'(req_ready), 32'(!stall));
      if (req_ready)
        check("idle_outputs_zero", mem_addr | mem_write_data | 32'(mem_sign_mask) |
              32'({mem_memread, mem_memwrite, resp_valid, resp_err}), 32'h0);
      if (mem_memread) act_rd++;
      if (mem_memwrite) act_wr++;
      if (mem_memread || mem_memwrite) begin
        if (acc_q.size() == 0) begin
          check("unexpected_strobe", 32'({mem_memread, mem_memwrite}), 32'h0);
        end else begin
          a = acc_q.pop_front();
          check("strobe_cycle", cyc, a.cyc);
          check("strobe_dir", 32'({mem_memread, mem_memwrite}), a.wr ? 32'h1 : 32'h2);
          check("strobe_addr", mem_addr, a.addr);
          check("strobe_mask", 32'(mem_sign_mask), 32'(a.mask));
          if (a.wr) check("strobe_wdata", mem_write_data, a.wdata);
        end
      end
      if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        check("missing_strobe", cyc, acc_q[0].cyc);
        void'(acc_q.pop_front());
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          r = exp_q.pop_front();
          check("resp_cycle", cyc, r.cyc);
          check("resp_err", 32'(resp_err), 32'(r.err));
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_stall", 32'(stall), 32'h1);
          if (!r.err) begin
            check("resp_hold_addr", mem_addr, r.addr);
            check("resp_hold_mask", 32'(mem_sign_mask), 32'(r.mask));
            check("resp_hold_wdata", mem_write_data, r.wdata);
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_resp", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit keep, output int unsigned acc);
    int n = 0;
    logic err;
    logic [3:0] mask;
    int width;
    acc_t  ea;
    resp_t er;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    ref_decode(w, f3, a, err, mask, width);
    er = '{err: err, rdata: '0, addr: a, wdata: '0, mask: mask, cyc: acc + 1};
    if (!err) begin
      ea = '{wr: w, addr: a, wdata: '0, mask: mask, cyc: acc + 1};
      if (w) begin
        ea.wdata = wd << (8 * a[1:0]);
        er.wdata = ea.wdata;
        er.cyc   = acc + 2;
        exp_wr++;
        if (a != LED)
          for (int i = 0; i < width; i++) ref_mem[int'(a - BASE) + i] = wd[8*i +: 8];
      end else begin
        er.rdata = ref_load(a, width, mask[3]);
        er.cyc   = acc + 3;
        exp_rd++;
      end
      acc_q.push_back(ea);
    end
    exp_q.push_back(er);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size() + acc_q.size()), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned acc, acc_l, acc_s;
    logic [31:0] a;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_read_data = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      ref_mem[i] = 8'($urandom);
      dev_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'h1);
    check("reset_outputs", mem_addr | mem_write_data | resp_rdata | 32'(mem_sign_mask) |
          32'({mem_memread, mem_memwrite, resp_valid, resp_err, stall}) | 32'(dbg_state), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // LW of a known word
    poke(32'h1004, 32'hDEAD_BEEF);
    issue(1'b0, F3_LW, 32'h1004, 32'h0, 1'b0, acc);
    drain();

    // SB into lane 2, stall window
    issue(1'b1, F3_SB, 32'h1006, 32'h0000_00A5, 1'b0, acc);
    check("sb_stall_n1", 32'(stall), 32'h1);
    @(negedge clk);
    check("sb_stall_n2", 32'(stall), 32'h1);
    @(negedge clk);
    check("sb_stall_n3", 32'(stall), 32'h0);
    drain();

    // misaligned half load
    issue(1'b0, F3_LH, 32'h1003, 32'h0, 1'b0, acc);
    drain();

    // LED store and unmapped loads
    issue(1'b1, F3_SW, LED, 32'h0000_005A, 1'b0, acc);
    drain();
    check("led_value", led_reg, 32'h0000_005A);
    issue(1'b0, F3_LW, LED, 32'h0, 1'b0, acc);
    issue(1'b0, F3_LW, 32'h0FFC, 32'h0, 1'b0, acc);
    drain();

    // back-to-back with req_valid held
    issue(1'b0, F3_LW, 32'h1008, 32'h0, 1'b1, acc_l);
    issue(1'b1, F3_SW, 32'h100C, 32'h1234_5678, 1'b0, acc_s);
    check("b2b_accept_cycle", acc_s, acc_l + 4);
    drain();

    // reset while waiting for read data
    poke(32'h1000, 32'h0000_8000);
    issue(1'b0, F3_LW, 32'h1010, 32'h0, 1'b0, acc);
    @(negedge clk);
    check("pre_reset_state", 32'(dbg_state), 32'(ST_RD_WAIT));
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_reset_ready", 32'(req_ready), 32'h1);
    check("post_reset_no_resp", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    issue(1'b0, F3_LBU, 32'h1001, 32'h0, 1'b0, acc);
    drain();

    // randomized mix
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + $urandom_range(0, SIZE - 1);
        6:       a = LED;
        7:       a = LED + $urandom_range(1, 4);
        8:       a = BASE - 4 + $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            ($urandom_range(0, 3) == 0), acc);
      if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("read_strobe_count", 32'(act_rd), 32'(exp_rd));
    check("write_strobe_count", 32'(act_wr), 32'(exp_wr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
